clk_div_ctrl: RTL and testbench

//   Run-time programmable integer clock divider with sequencing control.

---
 rtl/clk_div_ctrl_if.sv | 24 ++
 rtl/clk_div_ctrl.sv | 111 +++++++++++
 tb/tb_clk_div_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration channel for clk_div_ctrl: valid/ready offer of a divide
// ratio plus a one-cycle error strobe for rejected ratios.
interface clk_div_ctrl_if #(
  parameter int W = 4
) ();
  logic         valid;
  logic [W-1:0] div;
  logic         ready;
  logic         err;

  modport master (
    output valid,
    output div,
    input  ready,
    input  err
  );

  modport slave (
    input  valid,
    input  div,
    output ready,
    output err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time programmable integer clock divider; ratio changes and stop requests
// take effect only on a period boundary so clk_out never glitches.
//
// state  | meaning
// S_IDLE | divided clock stopped, clk_out low, ratio may be written directly
// S_RUN  | dividing, no ratio pending, ratio offers accepted
// S_PEND | dividing, one ratio waiting for the next period boundary
// S_STOP | dividing, en dropped: finish the current period then go idle
module clk_div_ctrl #(
  parameter int W       = 4,
  parameter int DEF_DIV = 5
) (
  input  logic         Clk,
  input  logic         rst_n,
  input  logic         en,
  clk_div_ctrl_if.slave cfg,
  output logic         clk_out,
  output logic         period_start,
  output logic         running,
  output logic [W-1:0] cur_div
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_STOP
  } state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] pend_div;
  logic         pend_vld;
  logic         p;
  logic         n;

  logic         xfer;
  logic         cfg_legal;
  logic         new_pend;
  logic         at_end;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] half_cur;

  assign cfg.ready    = (state == S_IDLE) || (state == S_RUN);
  assign xfer         = cfg.valid & cfg.ready;
  assign cfg_legal    = (cfg.div >= W'(2));
  assign new_pend     = (state == S_RUN) & xfer & cfg_legal;
  assign at_end       = (cnt == (cur_div - W'(1)));
  assign cnt_inc      = cnt + W'(1);
  assign half_cur     = cur_div >> 1;

  assign running      = (state != S_IDLE);
  assign period_start = running & (cnt == '0);
  assign clk_out      = p | n;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      p        <= 1'b0;
      cur_div  <= W'(DEF_DIV);
      pend_div <= '0;
      pend_vld <= 1'b0;
      cfg.err  <= 1'b0;
    end else begin
      cfg.err <= xfer & ~cfg_legal;
      if (state == S_IDLE) begin
        if (xfer && cfg_legal) cur_div <= cfg.div;
        if (en) begin
          state <= S_RUN;
          cnt   <= '0;
          p     <= 1'b1;
        end
      end else if (at_end) begin
        cnt <= '0;
        if (!en) begin
          // Stopping on this boundary: a ratio accepted on this very edge
          // has no period left to wait for, so it lands directly.
          state    <= S_IDLE;
          p        <= 1'b0;
          pend_vld <= 1'b0;
          if (new_pend) cur_div <= cfg.div;
          else if (pend_vld) cur_div <= pend_div;
        end else begin
          p <= 1'b1;
          if (pend_vld) cur_div <= pend_div;
          pend_vld <= new_pend;
          if (new_pend) pend_div <= cfg.div;
          state <= new_pend ? S_PEND : S_RUN;
        end
      end else begin
        cnt <= cnt_inc;
        p   <= (cnt_inc < half_cur);
        if (new_pend) begin
          pend_div <= cfg.div;
          pend_vld <= 1'b1;
        end
        if (!en) state <= S_STOP;
        else if (pend_vld || new_pend) state <= S_PEND;
        else state <= S_RUN;
      end
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge Clk or negedge rst_n) begin
    if (!rst_n) n <= 1'b0;
    else        n <= cur_div[0] & (state != S_IDLE) & p;
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, directed sequences and a
// randomized run compared against a period-level reference model.
module tb_clk_div_ctrl;

  logic       Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clk_out;
  logic       period_start;
  logic       running;
  logic [3:0] cur_div;

  int checks = 0;
  int failures = 0;

  clk_div_ctrl_if #(.W(4)) cfg_if ();

  clk_div_ctrl #(.W(4), .DEF_DIV(5)) dut (
    .Clk          (Clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg          (cfg_if),
    .clk_out      (clk_out),
    .period_start (period_start),
    .running      (running),
    .cur_div      (cur_div)
  );

  initial forever #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the divided clock is high for the first N/2 Clk cycles
  // of each N-cycle period; ratios wait in a one-deep queue for a boundary.
  bit  m_act;
  bit  m_last_en;
  bit  m_err;
  int  m_pos;
  int  m_div;
  int  m_pend[$];

  function automatic bit m_ready();
    return !m_act || (m_last_en && m_pend.size() == 0);
  endfunction

  task automatic model_reset();
    m_act = 0; m_last_en = 0; m_err = 0; m_pos = 0; m_div = 5;
    m_pend.delete();
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit xfer;
    bit legal;
    xfer  = v && m_ready();
    legal = (d >= 2);
    m_err = xfer && !legal;
    if (!m_act) begin
      if (xfer && legal) m_div = d;
      if (e) begin
        m_act = 1;
        m_pos = 0;
      end
    end else if (m_pos == m_div - 1) begin
      m_pos = 0;
      if (m_pend.size() > 0) m_div = m_pend.pop_front();
      if (xfer && legal) begin
        if (e) m_pend.push_back(d);
        else   m_div = d;
      end
      if (!e) m_act = 0;
    end else begin
      m_pos++;
      if (xfer && legal) m_pend.push_back(d);
    end
    m_last_en = e;
  endtask

  logic obs_h1, obs_h2, obs_ps;

  task automatic cycle();
    bit exp_h1, exp_h2;
    @(posedge Clk);
    model_step(en, cfg_if.valid, int'(cfg_if.div));
    #1;
    exp_h1 = m_act && (2 * m_pos < m_div);
    exp_h2 = m_act && (2 * m_pos + 1 < m_div);
    chk("clk_out_first_half", clk_out, exp_h1);
    chk("running", running, m_act);
    chk("cur_div", cur_div, m_div);
    chk("period_start", period_start, m_act && m_pos == 0);
    chk("cfg_ready", cfg_if.ready, m_ready());
    chk("cfg_err", cfg_if.err, m_err);
    obs_h1 = clk_out;
    obs_ps = period_start;
    @(negedge Clk);
    #1;
    chk("clk_out_second_half", clk_out, exp_h2);
    obs_h2 = clk_out;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cfg_if.valid = 1'b0;
    cfg_if.div = 4'd0;
    @(posedge Clk);
    @(negedge Clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit en; bit valid; int div;
    bit e_run; int e_div; bit e_h1; bit e_h2; bit e_ps; bit e_rdy; bit e_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int hi;
    int ps_cnt;

    tbl[0] = '{0, 1, 4,  0, 4, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 0, 0,  1, 4, 1, 1, 1, 1, 0};
    tbl[2] = '{1, 0, 0,  1, 4, 1, 1, 0, 1, 0};
    tbl[3] = '{1, 0, 0,  1, 4, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 0,  1, 4, 0, 0, 0, 1, 0};
    tbl[5] = '{1, 1, 1,  1, 4, 1, 1, 1, 1, 1};
    tbl[6] = '{1, 1, 0,  1, 4, 1, 1, 0, 1, 1};
    tbl[7] = '{1, 0, 0,  1, 4, 0, 0, 0, 1, 0};
    tbl[8] = '{1, 0, 0,  1, 4, 0, 0, 0, 1, 0};
    tbl[9] = '{1, 0, 0,  1, 4, 1, 1, 1, 1, 0};

    // Reset values
    cfg_if.valid = 1'b0;
    cfg_if.div = 4'd0;
    #12;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_running", running, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_cur_div", cur_div, 5);
    chk("rst_cfg_ready", cfg_if.ready, 1);
    chk("rst_cfg_err", cfg_if.err, 0);
    @(negedge Clk);
    #1;
    rst_n = 1'b1;

    // Vector table: even ratio from idle, illegal ratios while running
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en;
      cfg_if.valid = tbl[i].valid;
      cfg_if.div = 4'(tbl[i].div);
      @(posedge Clk);
      #1;
      chk("tbl_running", running, tbl[i].e_run);
      chk("tbl_cur_div", cur_div, tbl[i].e_div);
      chk("tbl_clk_out_h1", clk_out, tbl[i].e_h1);
      chk("tbl_period_start", period_start, tbl[i].e_ps);
      chk("tbl_cfg_ready", cfg_if.ready, tbl[i].e_rdy);
      chk("tbl_cfg_err", cfg_if.err, tbl[i].e_err);
      @(negedge Clk);
      #1;
      chk("tbl_clk_out_h2", clk_out, tbl[i].e_h2);
    end

    // Default ratio 5: 2.5-cycle high phase, period_start every 5 cycles
    do_reset();
    en = 1'b1;
    hi = 0;
    ps_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i < 5) hi += int'(obs_h1) + int'(obs_h2);
      ps_cnt += int'(obs_ps);
    end
    chk("div5_high_halves", hi, 5);
    chk("div5_period_starts", ps_cnt, 2);

    // Asynchronous reset in the middle of a high phase
    cycle();
    chk("pre_reset_high", obs_h2, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", clk_out, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_cur_div", cur_div, 5);
    @(negedge Clk);
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    model_reset();
    cycle();
    chk("post_reset_running", running, 0);

    // Ratio change 5 -> 7 offered at cnt=1
    do_reset();
    en = 1'b1;
    cycle();
    cycle();
    cfg_if.valid = 1'b1;
    cfg_if.div = 4'd7;
    cycle();
    cfg_if.valid = 1'b0;
    chk("pend_ready_low", cfg_if.ready, 0);
    chk("pend_old_div", cur_div, 5);
    cycle();
    cycle();
    chk("pend_still_old_div", cur_div, 5);
    cycle();
    chk("boundary_new_div", cur_div, 7);
    chk("boundary_period_start", obs_ps, 1);
    chk("boundary_ready_back", cfg_if.ready, 1);
    hi = int'(obs_h1) + int'(obs_h2);
    repeat (6) begin
      cycle();
      hi += int'(obs_h1) + int'(obs_h2);
    end
    chk("div7_high_halves", hi, 7);
    cycle();
    chk("div7_next_period", obs_ps, 1);

    // Stop at cnt=2 with N=6, then stop/resume without a gap
    do_reset();
    cfg_if.valid = 1'b1;
    cfg_if.div = 4'd6;
    cycle();
    cfg_if.valid = 1'b0;
    en = 1'b1;
    cycle();
    cycle();
    cycle();
    en = 1'b0;
    cycle();
    chk("stop_still_running", running, 1);
    chk("stop_ready_low", cfg_if.ready, 0);
    cycle();
    cycle();
    cycle();
    chk("stop_idle_running", running, 0);
    chk("stop_idle_clk_out", obs_h1, 0);
    en = 1'b1;
    cycle();
    cycle();
    cycle();
    en = 1'b0;
    cycle();
    cycle();
    en = 1'b1;
    cycle();
    cycle();
    chk("resume_running", running, 1);
    chk("resume_period_start", obs_ps, 1);
    chk("resume_clk_high", obs_h1, 1);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cfg_if.valid = ($urandom_range(0, 3) == 0);
      cfg_if.div = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
